// File: rtl/pca_reconstruct.sv
// pca_reconstruct: time-multiplexed inverse PCA, x_hat = mu + W^T*y in Q4.12
module pca_reconstruct #(
    parameter int D      = 4,
    parameter int K      = 2,
    parameter int IN_W   = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int FRAC   = 12,
    parameter int ACC_W  = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*IN_W-1:0]    y_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D*OUT_W-1:0]   x_flat
);
    localparam int DW = D > 1 ? $clog2(D) : 1;
    localparam int KW = K > 1 ? $clog2(K) : 1;
    localparam int PW = IN_W + COEF_W;
    localparam logic signed [ACC_W-1:0] SMAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                    state_q, state_d;
    logic [DW-1:0]             d_q, d_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_next, rnd, sum;
    logic [K*IN_W-1:0]         y_q, y_d;
    logic [D*OUT_W-1:0]        x_q, x_d;
    logic signed [IN_W-1:0]    y_sel;
    logic signed [PW-1:0]      prod;
    logic signed [OUT_W-1:0]   sat;

    function automatic logic signed [COEF_W-1:0] w_rom(input int k, input int d);
        logic signed [COEF_W-1:0] r;
        r = '0;
        if (k == 0)
            case (d)
                0: r = COEF_W'(1480);
                1: r = COEF_W'(-346);
                2: r = COEF_W'(3509);
                3: r = COEF_W'(1468);
                default: r = '0;
            endcase
        else if (k == 1)
            case (d)
                0: r = COEF_W'(2689);
                1: r = COEF_W'(2991);
                2: r = COEF_W'(-710);
                3: r = COEF_W'(-309);
                default: r = '0;
            endcase
        return r;
    endfunction

    function automatic logic signed [COEF_W-1:0] mu_rom(input int d);
        logic signed [COEF_W-1:0] r;
        case (d)
            0: r = COEF_W'(23934);
            1: r = COEF_W'(12524);
            2: r = COEF_W'(15393);
            3: r = COEF_W'(4912);
            default: r = '0;
        endcase
        return r;
    endfunction

    // One MAC step plus the round/offset/saturate path for the element being finished
    always_comb begin
        y_sel    = y_q[k_q*IN_W +: IN_W];
        prod     = PW'(y_sel) * PW'(w_rom(int'(k_q), int'(d_q)));
        acc_next = acc_q + ACC_W'(prod);
        rnd      = (acc_next + HALF) >>> FRAC;
        sum      = rnd + ACC_W'(mu_rom(int'(d_q)));
        sat      = sum > SMAX ? SMAX[OUT_W-1:0] : sum < SMIN ? SMIN[OUT_W-1:0] : sum[OUT_W-1:0];
    end

    // Next-state and handshake outputs; results only ever leave through x_q
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        k_d       = k_q;
        acc_d     = acc_q;
        y_d       = y_q;
        x_d       = x_q;
        in_ready  = state_q == IDLE;
        out_valid = state_q == OUT;
        case (state_q)
            IDLE: if (in_valid) begin
                y_d     = y_flat;
                acc_d   = '0;
                d_d     = '0;
                k_d     = '0;
                state_d = CALC;
            end
            CALC: if (k_q == KW'(K - 1)) begin
                x_d[d_q*OUT_W +: OUT_W] = sat;
                acc_d = '0;
                k_d   = '0;
                if (d_q == DW'(D - 1)) state_d = OUT;
                else d_d = d_q + DW'(1);
            end else begin
                acc_d = acc_next;
                k_d   = k_q + KW'(1);
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any vector in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            x_q     <= x_d;
        end
    end

    assign x_flat = x_q;
endmodule

// File: tb/tb_pca_reconstruct.sv
// tb_pca_reconstruct: directed vector table plus handshake/reset corner sequences
module tb_pca_reconstruct;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] y_flat = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] x_flat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int y0;
        int y1;
        int x[4];
    } vec_t;

    vec_t vt[7];

    pca_reconstruct dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y_flat(y_flat), .out_valid(out_valid), .out_ready(out_ready), .x_flat(x_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int xe(input int d);
        return int'($signed(x_flat[d*16 +: 16]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("wait_in_ready", int'(in_ready), 1);
    endtask

    task automatic send(input vec_t v);
        wait_ready();
        y_flat   = {16'(v.y1), 16'(v.y0)};
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        out_ready = 1;
        send(v);
        chk({tag, "_busy"}, int'(in_ready), 0);
        wait_out(lat);
        chk({tag, "_latency"}, lat, 8);
        for (int d = 0; d < 4; d++) chk($sformatf("%s_x%0d", tag, d), xe(d), v.x[d]);
        tick();
        chk({tag, "_one_cycle"}, int'(out_valid), 0);
        chk({tag, "_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat, ns, nr, cyc, last, extra;
        vt[0] = '{0, 0, '{23934, 12524, 15393, 4912}};
        vt[1] = '{4096, 0, '{25414, 12178, 18902, 6380}};
        vt[2] = '{0, 4096, '{26623, 15515, 14683, 4603}};
        vt[3] = '{32767, 0, '{32767, 9756, 32767, 16656}};
        vt[4] = '{-4096, -4096, '{19765, 9879, 12594, 3753}};
        vt[5] = '{0, 2048, '{25279, 14020, 15038, 4758}};
        vt[6] = '{32767, -32768, '{14262, -14172, 32767, 19128}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x_zero", int'(x_flat != 0), 0);
        rst = 0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // back-pressure: result must hold while out_ready is low
        out_ready = 0;
        send(vt[1]);
        wait_out(lat);
        chk("bp_latency", lat, 8);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_x0", xe(0), 25414);
            chk("bp_x3", xe(3), 6380);
            in_valid = i[0];
            y_flat   = {16'(i * 100), 16'(i * 77)};
            tick();
        end
        in_valid  = 0;
        out_ready = 1;
        tick();
        chk("bp_released", int'(out_valid), 0);
        chk("bp_ready_next", int'(in_ready), 1);
        chk("bp_x_held", xe(1), 12178);
        tick();
        chk("bp_no_phantom", int'(in_ready), 1);

        // reset three cycles into the computation
        send(vt[2]);
        tick();
        tick();
        chk("mid_busy", int'(in_ready), 0);
        rst = 1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_x_zero", int'(x_flat != 0), 0);
        tick();
        tick();
        rst = 0;
        run_vec(vt[0], "post_rst");

        // back-to-back with both handshakes held high
        ns = 0; nr = 0; cyc = 0; last = 0;
        out_ready = 1;
        while (nr < 4 && cyc < 200) begin
            if (out_valid) begin
                for (int d = 0; d < 4; d++) chk($sformatf("b2b%0d_x%0d", nr, d), xe(d), vt[nr + 1].x[d]);
                if (nr > 0) chk("b2b_gap", cyc - last, 10);
                last = cyc;
                nr++;
            end
            if (in_ready && ns < 4) begin
                y_flat   = {16'(vt[ns + 1].y1), 16'(vt[ns + 1].y0)};
                in_valid = 1;
                ns++;
            end else if (in_ready) in_valid = 0;
            tick();
            cyc++;
        end
        in_valid = 0;
        chk("b2b_count", nr, 4);
        extra = 0;
        repeat (15) begin
            tick();
            if (out_valid) extra++;
        end
        chk("b2b_no_dup", extra, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
